tv_axi_bridge: RTL and testbench



---
 rtl/tv_axi_bridge.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_tv_axi_bridge.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tv_axi_bridge.sv
// Test-vector read/write responder bridging the task manager to an AXI4-Lite master.
// Optional response-error capture is enabled by defining TV_AXI_BRIDGE_ERR_CAPTURE_EN.
//
// state   | meaning
// RD_IDLE | waiting for a queued request and space in the read-data FIFO
// RD_ADDR | araddr presented, arvalid held until arready
// RD_DATA | rready held until rvalid; data dropped if a flush hit this read
// WR_IDLE | TV_OUT_READY high, waiting for TV_OUT_WR_EN
// WR_SEND | awvalid/wvalid asserted, each dropping on its own ready
// WR_RESP | bready held until bvalid
module tv_axi_bridge #(
  parameter int M_AXI_DATA_WIDTH = 32,
  parameter int M_AXI_ADDR_WIDTH = 32,
  parameter int REQ_FIFO_DEPTH   = 16,
  parameter int RD_FIFO_DEPTH    = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [M_AXI_ADDR_WIDTH-1:0] TV_REQ_ADDR,
  input  logic                        TV_REQ_WR_EN,
  output logic                        TV_REQ_READY,
  input  logic                        i_flush,
  output logic [M_AXI_DATA_WIDTH-1:0] TV_IN_DATA,
  input  logic                        TV_IN_FIFO_RD_EN,
  output logic                        TV_IN_FIFO_NOT_EMPTY,
  output logic                        TV_IN_DATA_VALID,
  input  logic [M_AXI_DATA_WIDTH-1:0] TV_OUT_DATA,
  input  logic [M_AXI_ADDR_WIDTH-1:0] TV_OUT_ADDR,
  input  logic                        TV_OUT_WR_EN,
  output logic                        TV_OUT_READY,
  output logic [M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,
  output logic [M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]                  m_axi_wstrb,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic                        o_err,
  output logic [M_AXI_ADDR_WIDTH-1:0] o_err_addr
);

  localparam int RQ_AW = $clog2(REQ_FIFO_DEPTH);
  localparam int RD_AW = $clog2(RD_FIFO_DEPTH);
  localparam int RQ_PW = RQ_AW + 1;
  localparam int RD_PW = RD_AW + 1;
  localparam logic [RQ_PW-1:0] RQ_DEPTH_C = RQ_PW'(REQ_FIFO_DEPTH);
  localparam logic [RD_PW-1:0] RD_DEPTH_C = RD_PW'(RD_FIFO_DEPTH);

  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE, WR_SEND, WR_RESP} wr_state_e;

  logic [M_AXI_ADDR_WIDTH-1:0] rq_mem [REQ_FIFO_DEPTH];
  logic [M_AXI_DATA_WIDTH-1:0] rd_mem [RD_FIFO_DEPTH];

  logic [RQ_PW-1:0] rq_wptr_q, rq_wptr_d, rq_rptr_q, rq_rptr_d, rq_cnt;
  logic [RD_PW-1:0] rd_wptr_q, rd_wptr_d, rd_rptr_q, rd_rptr_d, rd_cnt;
  logic             rq_push, rq_pop, rd_push, rd_pop;
  logic             rst_done_q, rst_done_d;

  rd_state_e                   rd_state_q, rd_state_d;
  logic [M_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                        arvalid_q, arvalid_d, rready_q, rready_d, drop_q, drop_d;
  logic [M_AXI_DATA_WIDTH-1:0] tv_in_data_q, tv_in_data_d;
  logic                        tv_in_valid_q, tv_in_valid_d;

  wr_state_e                   wr_state_q, wr_state_d;
  logic [M_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                        aw_done, w_done;

  assign rq_cnt = rq_wptr_q - rq_rptr_q;
  assign rd_cnt = rd_wptr_q - rd_rptr_q;

  assign TV_REQ_READY         = rst_done_q && (rq_cnt < RQ_DEPTH_C);
  assign TV_IN_FIFO_NOT_EMPTY = (rd_cnt != '0);
  assign TV_OUT_READY         = rst_done_q && (wr_state_q == WR_IDLE);

  // A flush cycle accepts neither a push nor a pop on either FIFO.
  assign rq_push = TV_REQ_WR_EN && TV_REQ_READY && !i_flush;
  assign rd_pop  = TV_IN_FIFO_RD_EN && TV_IN_FIFO_NOT_EMPTY && !i_flush;

  assign rst_done_d = 1'b1;

  always_comb begin
    rd_state_d = rd_state_q;
    araddr_d   = araddr_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    drop_d     = drop_q;
    rq_pop     = 1'b0;
    rd_push    = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if ((rq_cnt != '0) && (rd_cnt < RD_DEPTH_C) && !i_flush) begin
          rq_pop     = 1'b1;
          araddr_d   = rq_mem[rq_rptr_q[RQ_AW-1:0]];
          arvalid_d  = 1'b1;
          rd_state_d = RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (i_flush) drop_d = 1'b1;
        if (m_axi_arready) begin
          arvalid_d  = 1'b0;
          rready_d   = 1'b1;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (i_flush) drop_d = 1'b1;
        if (m_axi_rvalid) begin
          rd_push    = !drop_q && !i_flush;
          rready_d   = 1'b0;
          drop_d     = 1'b0;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    rq_wptr_d     = rq_wptr_q + RQ_PW'(rq_push);
    rq_rptr_d     = rq_rptr_q + RQ_PW'(rq_pop);
    rd_wptr_d     = rd_wptr_q + RD_PW'(rd_push);
    rd_rptr_d     = rd_rptr_q + RD_PW'(rd_pop);
    tv_in_data_d  = rd_pop ? rd_mem[rd_rptr_q[RD_AW-1:0]] : tv_in_data_q;
    tv_in_valid_d = rd_pop;
    if (i_flush) begin
      rq_rptr_d = rq_wptr_q;
      rd_rptr_d = rd_wptr_q;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    aw_done    = 1'b0;
    w_done     = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (TV_OUT_WR_EN && TV_OUT_READY) begin
          awaddr_d   = TV_OUT_ADDR;
          wdata_d    = TV_OUT_DATA;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          wr_state_d = WR_SEND;
        end
      end
      WR_SEND: begin
        aw_done = !awvalid_q || m_axi_awready;
        w_done  = !wvalid_q || m_axi_wready;
        if (m_axi_awready) awvalid_d = 1'b0;
        if (m_axi_wready)  wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d   = 1'b1;
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          bready_d   = 1'b0;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (rq_push) rq_mem[rq_wptr_q[RQ_AW-1:0]] <= TV_REQ_ADDR;
    if (rd_push) rd_mem[rd_wptr_q[RD_AW-1:0]] <= m_axi_rdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rst_done_q    <= 1'b0;
      rq_wptr_q     <= '0;
      rq_rptr_q     <= '0;
      rd_wptr_q     <= '0;
      rd_rptr_q     <= '0;
      rd_state_q    <= RD_IDLE;
      araddr_q      <= '0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      drop_q        <= 1'b0;
      tv_in_data_q  <= '0;
      tv_in_valid_q <= 1'b0;
      wr_state_q    <= WR_IDLE;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
    end else begin
      rst_done_q    <= rst_done_d;
      rq_wptr_q     <= rq_wptr_d;
      rq_rptr_q     <= rq_rptr_d;
      rd_wptr_q     <= rd_wptr_d;
      rd_rptr_q     <= rd_rptr_d;
      rd_state_q    <= rd_state_d;
      araddr_q      <= araddr_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      drop_q        <= drop_d;
      tv_in_data_q  <= tv_in_data_d;
      tv_in_valid_q <= tv_in_valid_d;
      wr_state_q    <= wr_state_d;
      awaddr_q      <= awaddr_d;
      wdata_q       <= wdata_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
    end
  end

  assign TV_IN_DATA       = tv_in_data_q;
  assign TV_IN_DATA_VALID = tv_in_valid_q;
  assign m_axi_araddr     = araddr_q;
  assign m_axi_arvalid    = arvalid_q;
  assign m_axi_rready     = rready_q;
  assign m_axi_awaddr     = awaddr_q;
  assign m_axi_awvalid    = awvalid_q;
  assign m_axi_wdata      = wdata_q;
  assign m_axi_wstrb      = 4'hF;
  assign m_axi_wvalid     = wvalid_q;
  assign m_axi_bready     = bready_q;

`ifdef TV_AXI_BRIDGE_ERR_CAPTURE_EN
  logic                        err_q, err_d;
  logic [M_AXI_ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  // Only the first failing response is recorded; a read wins a same-cycle tie.
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (!err_q) begin
      if ((rd_state_q == RD_DATA) && m_axi_rvalid && (m_axi_rresp != 2'b00)) begin
        err_d      = 1'b1;
        err_addr_d = araddr_q;
      end else if ((wr_state_q == WR_RESP) && m_axi_bvalid && (m_axi_bresp != 2'b00)) begin
        err_d      = 1'b1;
        err_addr_d = awaddr_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign o_err      = err_q;
  assign o_err_addr = err_addr_q;
`else
  logic unused_resp;
  assign unused_resp = ^{m_axi_rresp, m_axi_bresp};
  assign o_err       = 1'b0;
  assign o_err_addr  = '0;
`endif

endmodule

// File: tb/tb_tv_axi_bridge.sv
// Scoreboard bench for tv_axi_bridge with behavioural AXI4-Lite slave models.
module tb_tv_axi_bridge;
  logic        i_clk, i_rst, i_flush;
  logic [31:0] TV_REQ_ADDR;
  logic        TV_REQ_WR_EN, TV_REQ_READY;
  logic [31:0] TV_IN_DATA;
  logic        TV_IN_FIFO_RD_EN, TV_IN_FIFO_NOT_EMPTY, TV_IN_DATA_VALID;
  logic [31:0] TV_OUT_DATA, TV_OUT_ADDR;
  logic        TV_OUT_WR_EN, TV_OUT_READY;
  logic [31:0] m_axi_araddr, m_axi_rdata, m_axi_awaddr, m_axi_wdata;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready;
  logic [1:0]  m_axi_rresp, m_axi_bresp;
  logic [3:0]  m_axi_wstrb;
  logic        o_err;
  logic [31:0] o_err_addr;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb[$];

  int ar_cnt = 0, b_cnt = 0, valid_seen = 0;
  int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [31:0] rd_err_addr = 32'hFFFF_FFFF;
  logic [1:0]  wr_bresp = 2'b00;
  logic [31:0] cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;
  bit          aw_dup = 0;

  tv_axi_bridge dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .TV_REQ_ADDR(TV_REQ_ADDR), .TV_REQ_WR_EN(TV_REQ_WR_EN), .TV_REQ_READY(TV_REQ_READY),
    .i_flush(i_flush),
    .TV_IN_DATA(TV_IN_DATA), .TV_IN_FIFO_RD_EN(TV_IN_FIFO_RD_EN),
    .TV_IN_FIFO_NOT_EMPTY(TV_IN_FIFO_NOT_EMPTY), .TV_IN_DATA_VALID(TV_IN_DATA_VALID),
    .TV_OUT_DATA(TV_OUT_DATA), .TV_OUT_ADDR(TV_OUT_ADDR), .TV_OUT_WR_EN(TV_OUT_WR_EN),
    .TV_OUT_READY(TV_OUT_READY),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .o_err(o_err), .o_err_addr(o_err_addr)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'hA000000) return ({30'd0, a[3:2]} + 32'd1) * 32'h11;
    return {a[15:0], ~a[15:0]};
  endfunction

  // AR/R slave: one read at a time with programmable delays.
  initial begin
    logic [31:0] a;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
    forever begin
      @(posedge i_clk); #1;
      if (m_axi_arvalid === 1'b1) begin
        repeat (ar_delay) begin @(posedge i_clk); #1; end
        a = m_axi_araddr;
        m_axi_arready = 1'b1;
        ar_cnt++;
        @(posedge i_clk); #1;
        m_axi_arready = 1'b0;
        repeat (r_delay) begin @(posedge i_clk); #1; end
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = mem_word(a);
        m_axi_rresp  = (a == rd_err_addr) ? 2'b10 : 2'b00;
        @(posedge i_clk); #1;
        m_axi_rvalid = 1'b0;
        m_axi_rresp  = 2'b00;
      end
    end
  end

  // AW/W/B slave: independent ready delays for address and data.
  initial begin
    int c;
    bit ad, wd;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    forever begin
      @(posedge i_clk); #1;
      if (m_axi_awvalid === 1'b1 || m_axi_wvalid === 1'b1) begin
        cap_awaddr = m_axi_awaddr; cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb;
        c = 0; ad = 0; wd = 0;
        while (!(ad && wd) && c < 50) begin
          if (ad && m_axi_awvalid === 1'b1) aw_dup = 1;
          m_axi_awready = !ad && (c == aw_delay);
          m_axi_wready  = !wd && (c == w_delay);
          @(posedge i_clk); #1;
          if (m_axi_awready) ad = 1;
          if (m_axi_wready)  wd = 1;
          m_axi_awready = 1'b0; m_axi_wready = 1'b0;
          c++;
        end
        repeat (b_delay) begin @(posedge i_clk); #1; end
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = wr_bresp;
        @(posedge i_clk); #1;
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
        b_cnt++;
      end
    end
  end

  // Output monitor: valid must follow an accepted pop by one cycle, data in order.
  initial begin
    logic [31:0] exp;
    bit pop_pending;
    pop_pending = 0;
    forever begin
      @(negedge i_clk);
      if (i_rst !== 1'b0) pop_pending = 0;
      else begin
        if (TV_IN_DATA_VALID === 1'b1 || pop_pending) begin
          vectors++;
          if (TV_IN_DATA_VALID !== pop_pending) begin
            miscompares++;
            $display("FAIL valid_timing: TV_IN_DATA_VALID=%0b required %0b", TV_IN_DATA_VALID, pop_pending);
          end
        end
        if (TV_IN_DATA_VALID === 1'b1) begin
          valid_seen++;
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_data: TV_IN_DATA=%h with no word outstanding", TV_IN_DATA);
          end else begin
            exp = sb.pop_front();
            if (TV_IN_DATA !== exp) begin
              miscompares++;
              $display("FAIL tv_in_data: got %h required %h", TV_IN_DATA, exp);
            end
          end
        end
        pop_pending = (TV_IN_FIFO_RD_EN === 1'b1) && (TV_IN_FIFO_NOT_EMPTY === 1'b1) && (i_flush === 1'b0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic push_req(input logic [31:0] a);
    int n;
    n = 0;
    TV_REQ_ADDR = a; TV_REQ_WR_EN = 1'b1;
    while (TV_REQ_READY !== 1'b1 && n < 200) begin tick(1); n++; end
    vectors++;
    if (TV_REQ_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL req_ready_timeout: TV_REQ_READY=%0b required 1", TV_REQ_READY);
    end else sb.push_back(mem_word(a));
    tick(1);
    TV_REQ_WR_EN = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin tick(1); n++; end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d words outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_flush = 1'b0; TV_REQ_ADDR = '0; TV_REQ_WR_EN = 1'b0;
    TV_IN_FIFO_RD_EN = 1'b0; TV_OUT_DATA = '0; TV_OUT_ADDR = '0; TV_OUT_WR_EN = 1'b0;
    tick(4);
    vectors++;
    if ({TV_REQ_READY, TV_OUT_READY, m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid,
         m_axi_bready, TV_IN_FIFO_NOT_EMPTY, TV_IN_DATA_VALID, o_err} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: outputs %b required all 0", {TV_REQ_READY, TV_OUT_READY, m_axi_arvalid,
               m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, TV_IN_FIFO_NOT_EMPTY, TV_IN_DATA_VALID, o_err});
    end
    vectors++;
    if (TV_IN_DATA !== 32'h0 || o_err_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: TV_IN_DATA=%h o_err_addr=%h required 0", TV_IN_DATA, o_err_addr);
    end
    i_rst = 1'b0;
    #1;
    vectors++;
    if (TV_REQ_READY !== 1'b0 || TV_OUT_READY !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_early: req=%0b out=%0b required 0 before first clock", TV_REQ_READY, TV_OUT_READY);
    end
    tick(1);
    vectors++;
    if (TV_REQ_READY !== 1'b1 || TV_OUT_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_rise: req=%0b out=%0b required 1", TV_REQ_READY, TV_OUT_READY);
    end
  endtask

  task automatic test_read_seq;
    int base_ar, base_v;
    ar_delay = 2; r_delay = 2;
    base_ar = ar_cnt; base_v = valid_seen;
    TV_IN_FIFO_RD_EN = 1'b1;
    push_req(32'hA000_0000);
    vectors++;
    if (m_axi_arvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL ar_latency_early: arvalid=%0b required 0", m_axi_arvalid);
    end
    push_req(32'hA000_0004);
    vectors++;
    if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'hA000_0000) begin
      miscompares++;
      $display("FAIL ar_latency: arvalid=%0b araddr=%h required 1 a0000000", m_axi_arvalid, m_axi_araddr);
    end
    push_req(32'hA000_0008);
    push_req(32'hA000_000C);
    wait_drain("read_seq_drain", 300);
    tick(5);
    vectors++;
    if (ar_cnt - base_ar != 4 || valid_seen - base_v != 4) begin
      miscompares++;
      $display("FAIL read_seq_count: ar=%0d valids=%0d required 4 4", ar_cnt - base_ar, valid_seen - base_v);
    end
    TV_IN_FIFO_RD_EN = 1'b0;
  endtask

  task automatic test_fill;
    int base_ar, n;
    ar_delay = 0; r_delay = 0;
    base_ar = ar_cnt;
    for (int i = 0; i < 16; i++) push_req(32'hB000_0000 + 32'(i * 4));
    n = 0;
    while (ar_cnt - base_ar < 16 && n < 300) begin tick(1); n++; end
    tick(20);
    vectors++;
    if (ar_cnt - base_ar != 16 || TV_IN_FIFO_NOT_EMPTY !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_ar: ar=%0d not_empty=%0b required 16 1", ar_cnt - base_ar, TV_IN_FIFO_NOT_EMPTY);
    end
    for (int i = 0; i < 16; i++) begin
      TV_REQ_ADDR = 32'hC000_0000 + 32'(i * 4); TV_REQ_WR_EN = 1'b1;
      vectors++;
      if (TV_REQ_READY !== 1'b1) begin
        miscompares++;
        $display("FAIL fill_ready_%0d: TV_REQ_READY=%0b required 1", i, TV_REQ_READY);
      end else sb.push_back(mem_word(TV_REQ_ADDR));
      tick(1);
    end
    vectors++;
    if (TV_REQ_READY !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_full: TV_REQ_READY=%0b required 0", TV_REQ_READY);
    end
    TV_REQ_ADDR = 32'hDEAD_0000;
    tick(1);
    TV_REQ_WR_EN = 1'b0;
    tick(5);
    vectors++;
    if (ar_cnt - base_ar != 16) begin
      miscompares++;
      $display("FAIL fill_no_17th: ar=%0d required 16", ar_cnt - base_ar);
    end
    TV_IN_FIFO_RD_EN = 1'b1;
    tick(1);
    TV_IN_FIFO_RD_EN = 1'b0;
    tick(10);
    vectors++;
    if (ar_cnt - base_ar != 17 || TV_REQ_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_drain_one: ar=%0d ready=%0b required 17 1", ar_cnt - base_ar, TV_REQ_READY);
    end
    TV_IN_FIFO_RD_EN = 1'b1;
    wait_drain("fill_drain_all", 600);
    tick(3);
    TV_IN_FIFO_RD_EN = 1'b0;
    vectors++;
    if (TV_IN_FIFO_NOT_EMPTY !== 1'b0 || ar_cnt - base_ar != 32) begin
      miscompares++;
      $display("FAIL fill_final: not_empty=%0b ar=%0d required 0 32", TV_IN_FIFO_NOT_EMPTY, ar_cnt - base_ar);
    end
  endtask

  task automatic test_flush;
    int base_ar, n;
    ar_delay = 0; r_delay = 6;
    base_ar = ar_cnt;
    for (int i = 0; i < 6; i++) push_req(32'hA100_0000 + 32'(i * 4));
    n = 0;
    while (!(ar_cnt - base_ar == 4 && m_axi_rready === 1'b1) && n < 200) begin tick(1); n++; end
    vectors++;
    if (n >= 200) begin
      miscompares++;
      $display("FAIL flush_setup: ar=%0d rready=%0b required 4 1", ar_cnt - base_ar, m_axi_rready);
    end
    i_flush = 1'b1;
    sb.delete();
    tick(1);
    i_flush = 1'b0;
    vectors++;
    if (TV_IN_FIFO_NOT_EMPTY !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_empty: not_empty=%0b required 0", TV_IN_FIFO_NOT_EMPTY);
    end
    TV_IN_FIFO_RD_EN = 1'b1;
    tick(30);
    TV_IN_FIFO_RD_EN = 1'b0;
    vectors++;
    if (TV_IN_FIFO_NOT_EMPTY !== 1'b0 || ar_cnt - base_ar != 4 || m_axi_rready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_discard: not_empty=%0b ar=%0d rready=%0b required 0 4 0",
               TV_IN_FIFO_NOT_EMPTY, ar_cnt - base_ar, m_axi_rready);
    end
    r_delay = 1;
    TV_IN_FIFO_RD_EN = 1'b1;
    push_req(32'hA000_0004);
    wait_drain("flush_recover", 100);
    tick(2);
    TV_IN_FIFO_RD_EN = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    while (TV_OUT_READY !== 1'b1 && n < 100) begin tick(1); n++; end
    TV_OUT_ADDR = a; TV_OUT_DATA = d; TV_OUT_WR_EN = 1'b1;
    tick(1);
    TV_OUT_WR_EN = 1'b0;
  endtask

  task automatic test_write;
    int n, base_b;
    aw_delay = 0; w_delay = 3; b_delay = 0; aw_dup = 0;
    base_b = b_cnt;
    do_write(32'hA000_2004, 32'hDEAD_BEEF);
    vectors++;
    if (TV_OUT_READY !== 1'b0 || m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_launch: ready=%0b awvalid=%0b wvalid=%0b required 0 1 1",
               TV_OUT_READY, m_axi_awvalid, m_axi_wvalid);
    end
    n = 0;
    @(negedge i_clk);
    while (m_axi_bvalid !== 1'b1 && n < 100) begin @(negedge i_clk); n++; end
    vectors++;
    if (m_axi_bvalid !== 1'b1 || TV_OUT_READY !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_bvalid: bvalid=%0b ready=%0b required 1 0", m_axi_bvalid, TV_OUT_READY);
    end
    @(posedge i_clk); #1;
    vectors++;
    if (TV_OUT_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_ready_return: TV_OUT_READY=%0b required 1", TV_OUT_READY);
    end
    vectors++;
    if (cap_awaddr !== 32'hA000_2004 || cap_wdata !== 32'hDEAD_BEEF || cap_wstrb !== 4'hF || aw_dup) begin
      miscompares++;
      $display("FAIL wr_payload: awaddr=%h wdata=%h wstrb=%h aw_dup=%0b required a0002004 deadbeef f 0",
               cap_awaddr, cap_wdata, cap_wstrb, aw_dup);
    end
    w_delay = 0;
    do_write(32'hA000_2008, 32'h0123_4567);
    vectors++;
    if (TV_OUT_READY !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_turn_c1: TV_OUT_READY=%0b required 0", TV_OUT_READY);
    end
    tick(1);
    vectors++;
    if (TV_OUT_READY !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_turn_c2: TV_OUT_READY=%0b required 0", TV_OUT_READY);
    end
    tick(1);
    vectors++;
    if (TV_OUT_READY !== 1'b1 || b_cnt - base_b != 2 || cap_wdata !== 32'h0123_4567) begin
      miscompares++;
      $display("FAIL wr_turn_c3: ready=%0b b=%0d wdata=%h required 1 2 01234567",
               TV_OUT_READY, b_cnt - base_b, cap_wdata);
    end
  endtask

  task automatic test_err;
    logic        exp_err;
    logic [31:0] exp_addr;
`ifdef TV_AXI_BRIDGE_ERR_CAPTURE_EN
    exp_err = 1'b1; exp_addr = 32'hA000_0008;
`else
    exp_err = 1'b0; exp_addr = 32'h0;
`endif
    vectors++;
    if (o_err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clean: o_err=%0b required 0", o_err);
    end
    ar_delay = 1; r_delay = 1;
    rd_err_addr = 32'hA000_0008;
    TV_IN_FIFO_RD_EN = 1'b1;
    for (int i = 0; i < 4; i++) push_req(32'hA000_0000 + 32'(i * 4));
    wait_drain("err_read_drain", 300);
    tick(2);
    TV_IN_FIFO_RD_EN = 1'b0;
    rd_err_addr = 32'hFFFF_FFFF;
    vectors++;
    if (o_err !== exp_err || o_err_addr !== exp_addr) begin
      miscompares++;
      $display("FAIL err_read: o_err=%0b o_err_addr=%h required %0b %h", o_err, o_err_addr, exp_err, exp_addr);
    end
    wr_bresp = 2'b10;
    do_write(32'hA000_3000, 32'h5555_AAAA);
    tick(6);
    wr_bresp = 2'b00;
    vectors++;
    if (o_err !== exp_err || o_err_addr !== exp_addr || TV_OUT_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: o_err=%0b o_err_addr=%h ready=%0b required %0b %h 1",
               o_err, o_err_addr, TV_OUT_READY, exp_err, exp_addr);
    end
  endtask

  initial begin
    test_reset();
    test_read_seq();
    test_fill();
    test_flush();
    test_write();
    test_err();
    tick(5);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: %0d words outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
